// File: rtl/polilock_pkg.sv
// Shared definitions for the Polilock event transmitter: event byte codes,
// TX FSM state encodings and the default bit period.
package polilock_pkg;

    localparam int unsigned CICLOS_POR_BIT_PADRAO = 434;

    localparam logic [7:0] COD_ACERTOU   = 8'h41;
    localparam logic [7:0] COD_ERROU     = 8'h45;
    localparam logic [7:0] COD_BLOQUEADO = 8'h42;

    typedef enum logic [3:0] {
        EstOcioso  = 4'd0,
        EstCarrega = 4'd1,
        EstPartida = 4'd2,
        EstDados   = 4'd3,
        EstParada  = 4'd4,
        EstFim     = 4'd5
    } estado_tx_t;

endpackage

// File: rtl/gerador_tick.sv
// Modulo-CICLOS_POR_BIT counter; fim pulses on the last cycle of each bit period.
module gerador_tick #(
    parameter int unsigned CICLOS_POR_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int unsigned LARGURA = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
    localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(CICLOS_POR_BIT - 1);

    logic [LARGURA-1:0] cont_q, cont_d;

    assign fim = conta && (cont_q == ULTIMO);

    always_comb begin
        cont_d = cont_q;
        if (zera) begin
            cont_d = '0;
        end else if (conta) begin
            cont_d = fim ? '0 : cont_q + LARGURA'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

endmodule

// File: rtl/transmissor_eventos.sv
// Turns rising edges of the lock outcome signals into ASCII bytes sent over
// a UART 8N1 line, one frame per pending event, highest priority first.
module transmissor_eventos
    import polilock_pkg::*;
#(
    parameter int unsigned CICLOS_POR_BIT = CICLOS_POR_BIT_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       acertou,
    input  logic       errou,
    input  logic       bloqueado,
    output logic       saida_serial,
    output logic       pronto,
    output logic [2:0] db_pendentes,
    output logic [3:0] db_estado
);

    // Bit order in all 3-bit vectors: {bloqueado, errou, acertou}
    logic [2:0] entrada_q, anterior_q, pend_q, pend_d;
    logic [2:0] borda, limpa;
    logic [7:0] desloc_q, desloc_d;
    logic [2:0] bit_q, bit_d;
    estado_tx_t estado_q, estado_d;
    logic       zera_tick, conta_tick, fim_tick;

    gerador_tick #(
        .CICLOS_POR_BIT(CICLOS_POR_BIT)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .zera (zera_tick),
        .conta(conta_tick),
        .fim  (fim_tick)
    );

    assign borda = entrada_q & ~anterior_q;
    // A new edge wins over the clear issued by the load in the same cycle.
    assign pend_d = (pend_q & ~limpa) | borda;

    always_comb begin
        estado_d     = estado_q;
        desloc_d     = desloc_q;
        bit_d        = bit_q;
        limpa        = 3'b000;
        zera_tick    = 1'b0;
        conta_tick   = 1'b0;
        saida_serial = 1'b1;
        case (estado_q)
            EstOcioso: begin
                if (pend_q != 3'b000) begin
                    estado_d = EstCarrega;
                end
            end
            EstCarrega: begin
                zera_tick = 1'b1;
                bit_d     = 3'd0;
                estado_d  = EstPartida;
                if (pend_q[0]) begin
                    desloc_d = COD_ACERTOU;
                    limpa    = 3'b001;
                end else if (pend_q[1]) begin
                    desloc_d = COD_ERROU;
                    limpa    = 3'b010;
                end else begin
                    desloc_d = COD_BLOQUEADO;
                    limpa    = 3'b100;
                end
            end
            EstPartida: begin
                saida_serial = 1'b0;
                conta_tick   = 1'b1;
                if (fim_tick) begin
                    estado_d = EstDados;
                end
            end
            EstDados: begin
                saida_serial = desloc_q[0];
                conta_tick   = 1'b1;
                if (fim_tick) begin
                    desloc_d = {1'b0, desloc_q[7:1]};
                    if (bit_q == 3'd7) begin
                        estado_d = EstParada;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            EstParada: begin
                conta_tick = 1'b1;
                if (fim_tick) begin
                    estado_d = EstFim;
                end
            end
            EstFim: begin
                estado_d = EstOcioso;
            end
            default: begin
                estado_d = EstOcioso;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entrada_q  <= 3'b000;
            anterior_q <= 3'b000;
            pend_q     <= 3'b000;
            desloc_q   <= 8'h00;
            bit_q      <= 3'd0;
            estado_q   <= EstOcioso;
        end else begin
            entrada_q  <= {bloqueado, errou, acertou};
            anterior_q <= entrada_q;
            pend_q     <= pend_d;
            desloc_q   <= desloc_d;
            bit_q      <= bit_d;
            estado_q   <= estado_d;
        end
    end

    assign pronto       = (estado_q == EstOcioso) && (pend_q == 3'b000);
    assign db_pendentes = pend_q;
    assign db_estado    = estado_q;

endmodule

// File: tb/tb_transmissor_eventos.sv
// Randomised and directed bench: a cycle-timer reference model predicts the
// line, status outputs and byte stream; an independent UART receiver decodes.
module tb_transmissor_eventos;

    localparam int N  = 4;
    localparam int FR = 10 * N + 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       acertou = 1'b0, errou = 1'b0, bloqueado = 1'b0;
    logic       saida_serial, pronto;
    logic [2:0] db_pendentes;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_errors = 0;

    transmissor_eventos #(
        .CICLOS_POR_BIT(N)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .acertou     (acertou),
        .errou       (errou),
        .bloqueado   (bloqueado),
        .saida_serial(saida_serial),
        .pronto      (pronto),
        .db_pendentes(db_pendentes),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: b counts cycles since the frame was scheduled
    // (0 idle, 1 load, 2..FR frame body up to the final idle-high cycle).
    logic [2:0] m_in, m_prev, m_pend;
    int         m_b;
    logic [7:0] m_byte;
    logic [7:0] m_q[$];

    function automatic logic [7:0] code_of(input logic [2:0] p);
        if (p[0]) return 8'h41;
        if (p[1]) return 8'h45;
        return 8'h42;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            if (m_b >= 2 && m_q.size() > 0) m_q.pop_back();
            m_in = 0; m_prev = 0; m_pend = 0; m_b = 0; m_byte = 0;
        end else begin
            logic [2:0] edg, clr;
            edg = m_in & ~m_prev;
            clr = 0;
            if (m_b == 0) begin
                if (m_pend != 0) m_b = 1;
            end else if (m_b == 1) begin
                m_byte = code_of(m_pend);
                clr = m_pend[0] ? 3'b001 : (m_pend[1] ? 3'b010 : 3'b100);
                m_q.push_back(m_byte);
                m_b = 2;
            end else if (m_b == FR) begin
                m_b = 0;
            end else begin
                m_b++;
            end
            m_pend = (m_pend & ~clr) | edg;
            m_prev = m_in;
            m_in = {bloqueado, errou, acertou};
        end
    end

    function automatic logic exp_line();
        if (m_b >= 2 && m_b <= N + 1) return 1'b0;
        if (m_b >= N + 2 && m_b <= 9 * N + 1) return m_byte[(m_b - N - 2) / N];
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_estado();
        if (m_b == 0) return 4'd0;
        if (m_b == 1) return 4'd1;
        if (m_b <= N + 1) return 4'd2;
        if (m_b <= 9 * N + 1) return 4'd3;
        if (m_b <= 10 * N + 1) return 4'd4;
        return 4'd5;
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            check("saida", 32'(saida_serial), 32'(exp_line()));
            check("pronto", 32'(pronto), 32'(m_b == 0 && m_pend == 0));
            check("pend", 32'(db_pendentes), 32'(m_pend));
            check("estado", 32'(db_estado), 32'(exp_estado()));
        end
    end

    // Independent receiver sampling mid-bit.
    logic [7:0] r_q[$];
    logic       r_busy = 1'b0;
    int         r_cnt;
    logic [7:0] r_byte;

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_busy = 1'b0;
        end else if (!r_busy) begin
            if (saida_serial == 1'b0) begin
                r_busy = 1'b1;
                r_cnt = 0;
            end
        end else begin
            r_cnt++;
            if (r_cnt >= N + N / 2 && r_cnt < 9 * N && (r_cnt - N - N / 2) % N == 0)
                r_byte[(r_cnt - N - N / 2) / N] = saida_serial;
            if (r_cnt == 9 * N + N / 2) begin
                check("stop", 32'(saida_serial), 32'd1);
                r_q.push_back(r_byte);
                r_busy = 1'b0;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse(input int which);
        @(negedge clock);
        if (which == 0) acertou = 1'b1;
        if (which == 1) errou = 1'b1;
        if (which == 2) bloqueado = 1'b1;
        @(negedge clock);
        acertou = 1'b0; errou = 1'b0; bloqueado = 1'b0;
    endtask

    task automatic expect_frames(input string tag, input int base, input int n,
                                 input logic [23:0] codes);
        check({tag, "_count"}, 32'(r_q.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < r_q.size())
                check({tag, "_byte"}, 32'(r_q[base + i]), 32'(codes[8 * i +: 8]));
        end
    endtask

    int base;

    initial begin
        // 1: idle after reset
        wait_cycles(3);
        #1 reset = 1'b1;
        wait_cycles(100);
        check("idle_pronto", 32'(pronto), 32'd1);
        check("idle_estado", 32'(db_estado), 32'd0);
        check("idle_frames", 32'(r_q.size()), 32'd0);

        // 2: single acertou pulse
        base = r_q.size();
        pulse(0);
        wait_cycles(60);
        expect_frames("single", base, 1, 24'h000041);
        check("single_pronto", 32'(pronto), 32'd1);

        // 3: errou and bloqueado together
        base = r_q.size();
        @(negedge clock);
        errou = 1'b1; bloqueado = 1'b1;
        @(negedge clock);
        errou = 1'b0; bloqueado = 1'b0;
        wait_cycles(2 * FR + 20);
        expect_frames("pair", base, 2, 24'h004245);

        // 4: errou repeats merged during a frame
        base = r_q.size();
        pulse(0);
        for (int i = 0; i < 3; i++) begin
            wait_cycles(6);
            pulse(1);
        end
        wait_cycles(2 * FR + 20);
        expect_frames("merge", base, 2, 24'h004541);

        // 5: reset during data bits
        pulse(0);
        wait_cycles(18);
        #1 reset = 1'b0;
        #1;
        check("rst_saida", 32'(saida_serial), 32'd1);
        check("rst_pend", 32'(db_pendentes), 32'd0);
        check("rst_estado", 32'(db_estado), 32'd0);
        wait_cycles(2);
        #1 reset = 1'b1;
        base = r_q.size();
        wait_cycles(80);
        expect_frames("after_rst", base, 0, 24'h0);

        // 6: bloqueado held across reset release
        @(negedge clock);
        #1 reset = 1'b0;
        bloqueado = 1'b1;
        wait_cycles(3);
        #1 reset = 1'b1;
        base = r_q.size();
        wait_cycles(60);
        expect_frames("held", base, 1, 24'h000042);
        wait_cycles(200);
        expect_frames("held_level", base, 1, 24'h000042);
        bloqueado = 1'b0;
        wait_cycles(5);
        bloqueado = 1'b1;
        wait_cycles(60);
        expect_frames("held_again", base, 2, 24'h004242);
        bloqueado = 1'b0;
        wait_cycles(5);

        // 7: random activity
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            if ($urandom_range(39) == 0) acertou = ~acertou;
            if ($urandom_range(39) == 0) errou = ~errou;
            if ($urandom_range(39) == 0) bloqueado = ~bloqueado;
        end
        acertou = 1'b0; errou = 1'b0; bloqueado = 1'b0;
        wait_cycles(4 * FR + 20);

        check("total_frames", 32'(r_q.size()), 32'(m_q.size()));
        for (int i = 0; i < r_q.size() && i < m_q.size(); i++)
            check("stream_byte", 32'(r_q[i]), 32'(m_q[i]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
